time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper_pkg.sv | 33 +++
 rtl/time_keeper_prescaler.sv | 43 ++++
 rtl/time_keeper.sv | 71 +++++++
 tb/tb_time_keeper.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared clock-face constants: BCD digit width, field limits and the
// two-digit BCD increment used by the time chain and the seven-segment stage.
package time_keeper_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    digit_t tens;
    digit_t ones;
  } bcd2_t;

  localparam bcd2_t SEC_LIM = '{tens: digit_t'(5), ones: digit_t'(9)};
  localparam bcd2_t MIN_LIM = '{tens: digit_t'(5), ones: digit_t'(9)};
  localparam bcd2_t HR_LIM  = '{tens: digit_t'(2), ones: digit_t'(3)};

  // Wraps to 00 at the limit, so an out-of-range code can never be formed.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t lim);
    bcd2_t r;
    r = v;
    if (v == lim) begin
      r = '0;
    end else if (v.ones == digit_t'(9)) begin
      r.tens = v.tens + digit_t'(1);
      r.ones = '0;
    end else begin
      r.ones = v.ones + digit_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/time_keeper_prescaler.sv
// Divides clk down to a one-second tick; half is registered and tracks
// whether the current count is in the first half of the second.
module tick_prescaler #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clear,
  output logic tick,
  output logic half
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_HZ / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign tick = run_en && (cnt == CNT_MAX);

  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (run_en) begin
      cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  // half is computed from the next count so it is a flop yet matches cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      half <= 1'b1;
    end else begin
      cnt  <= cnt_next;
      half <= (cnt_next < CNT_HALF);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// HH:MM clock with hidden seconds, driven by a one-second prescaler tick;
// set pulses bump minutes/hours and restart the current second.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  input  logic               set_min,
  input  logic               set_hr,
  output logic [DIGIT_W-1:0] hr_tens,
  output logic [DIGIT_W-1:0] hr_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic               colon,
  output logic               sec_tick
);

  logic  tick;
  logic  half;
  logic  set_any;
  bcd2_t sec_q;
  bcd2_t min_q;
  bcd2_t hr_q;

  assign set_any = set_min | set_hr;

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run_en (run_en),
    .clear  (set_any),
    .tick   (tick),
    .half   (half)
  );

  // A set pulse wins over a coincident tick; that tick is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q    <= '0;
      min_q    <= '0;
      hr_q     <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      if (set_any) begin
        sec_q <= '0;
        if (set_min) min_q <= bcd_inc(min_q, MIN_LIM);
        if (set_hr)  hr_q  <= bcd_inc(hr_q, HR_LIM);
      end else if (tick) begin
        sec_tick <= 1'b1;
        sec_q    <= bcd_inc(sec_q, SEC_LIM);
        if (sec_q == SEC_LIM) begin
          min_q <= bcd_inc(min_q, MIN_LIM);
          if (min_q == MIN_LIM) hr_q <= bcd_inc(hr_q, HR_LIM);
        end
      end
    end
  end

  assign hr_tens  = hr_q.tens;
  assign hr_ones  = hr_q.ones;
  assign min_tens = min_q.tens;
  assign min_ones = min_q.ones;
  assign colon    = half;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: an integer time model pushes the expected
// outputs per cycle, popped and compared one edge later.
module tb_time_keeper;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic       set_min;
  logic       set_hr;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic       colon;
  logic       sec_tick;

  typedef struct {
    int digits;
    int colon;
    int tick;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   m_pre, m_sec, m_min, m_hr, m_colon, m_tick;

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .set_min  (set_min),
    .set_hr   (set_hr),
    .hr_tens  (hr_tens),
    .hr_ones  (hr_ones),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .colon    (colon),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int digits_of(input int h, input int m);
    return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
  endfunction

  function automatic int dut_digits();
    return int'({hr_tens, hr_ones, min_tens, min_ones});
  endfunction

  task automatic model_reset();
    m_pre = 0; m_sec = 0; m_min = 0; m_hr = 0; m_colon = 1; m_tick = 0;
  endtask

  task automatic step(input bit ren, input bit sm, input bit sh);
    exp_t e;
    exp_t g;
    bit   tk;
    run_en  = ren;
    set_min = sm;
    set_hr  = sh;
    tk      = ren && (m_pre == CLK_HZ - 1);
    m_tick  = 0;
    if (sm || sh) begin
      m_pre = 0;
      m_sec = 0;
      if (sm) m_min = (m_min + 1) % 60;
      if (sh) m_hr  = (m_hr + 1) % 24;
    end else if (ren) begin
      m_pre = (m_pre + 1) % CLK_HZ;
      if (tk) begin
        m_tick = 1;
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min++;
          if (m_min == 60) begin
            m_min = 0;
            m_hr  = (m_hr + 1) % 24;
          end
        end
      end
    end
    m_colon  = (m_pre < CLK_HZ / 2) ? 1 : 0;
    e.digits = digits_of(m_hr, m_min);
    e.colon  = m_colon;
    e.tick   = m_tick;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk_val("digits", dut_digits(), g.digits);
    chk_val("colon", int'(colon), g.colon);
    chk_val("sec_tick", int'(sec_tick), g.tick);
    set_min = 1'b0;
    set_hr  = 1'b0;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_min_to(input int target);
    for (int i = 0; i < 60 && m_min != target; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_hr_to(input int target);
    for (int i = 0; i < 24 && m_hr != target; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_digits"}, dut_digits(), 0);
    chk_val({tag, "_colon"}, int'(colon), 1);
    chk_val({tag, "_sec_tick"}, int'(sec_tick), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcnt, tedge, chigh, mb, snap_d, snap_c;
    rst = 1'b1; run_en = 1'b0; set_min = 1'b0; set_hr = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // one second from reset: single tick on the 10th edge, colon 5 high / 5 low
    tcnt = 0; tedge = 0; chigh = 0;
    for (int i = 1; i <= CLK_HZ; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (sec_tick) begin tcnt++; tedge = i; end
      if (colon) chigh++;
    end
    chk_val("first_sec_ticks", tcnt, 1);
    chk_val("first_sec_edge", tedge, 10);
    chk_val("first_sec_colon_hi", chigh, 5);

    // 00:59:59 -> 01:00
    set_min_to(59);
    run_steps(59 * CLK_HZ);
    chk_val("at_005959", dut_digits(), 'h0059);
    run_steps(CLK_HZ);
    chk_val("hour_carry", dut_digits(), 'h0100);
    chk_val("hour_carry_tick", int'(sec_tick), 1);

    // 23:59:59 -> 00:00:00
    set_hr_to(23);
    set_min_to(59);
    run_steps(59 * CLK_HZ);
    chk_val("at_235959", dut_digits(), 'h2359);
    run_steps(CLK_HZ);
    chk_val("day_wrap", dut_digits(), 'h0000);
    chk_val("day_wrap_tick", int'(sec_tick), 1);

    // set pulses wrap without carry
    set_hr_to(12);
    set_min_to(59);
    chk_val("set_1259", dut_digits(), 'h1259);
    step(1'b0, 1'b1, 1'b0);
    chk_val("set_min_wrap", dut_digits(), 'h1200);
    set_hr_to(23);
    step(1'b0, 1'b0, 1'b1);
    chk_val("set_hr_wrap", dut_digits(), 'h0000);
    step(1'b0, 1'b1, 1'b1);
    chk_val("set_both", dut_digits(), 'h0101);

    // set_min coincident with a tick
    for (int i = 0; i < CLK_HZ && m_pre != CLK_HZ - 1; i++) step(1'b1, 1'b0, 1'b0);
    mb = m_min;
    step(1'b1, 1'b1, 1'b0);
    chk_val("set_vs_tick_tick", int'(sec_tick), 0);
    chk_val("set_vs_tick_min", int'(min_ones), (mb + 1) % 10);
    tedge = 0;
    for (int i = 1; i <= 2 * CLK_HZ; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (sec_tick && tedge == 0) tedge = i;
    end
    chk_val("tick_after_set", tedge, 10);

    // freeze, then async reset mid-second
    run_steps(7);
    snap_d = digits_of(m_hr, m_min);
    snap_c = m_colon;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0);
    chk_val("frozen_digits", dut_digits(), snap_d);
    chk_val("frozen_colon", int'(colon), snap_c);
    run_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_mid");
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tcnt = 0; tedge = 0;
    for (int i = 1; i <= CLK_HZ; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (sec_tick) begin tcnt++; tedge = i; end
    end
    chk_val("resume_ticks", tcnt, 1);
    chk_val("resume_edge", tedge, 10);
    chk_val("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
